// File: rtl/ip_uart_io.sv
// rtl/ip_uart_io.sv - Z80 I/O-mapped full-duplex UART with TX/RX FIFOs, sticky error flags and control register.
// Optional RX path (synchroniser, shifter, RX FIFO) is built only when IP_UART_IO_RX_EN is defined.
module ip_uart_io #(
    parameter int         clk_freq      = 27000000,
    parameter int         uart_freq     = 115200,
    parameter logic [7:0] io_base       = 8'h10,
    parameter int         tx_depth_log2 = 4,
    parameter int         rx_depth_log2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       iorq_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       q_en,
    output logic       uart_tx,
    input  logic       uart_rx
);
    localparam int DIV = clk_freq / uart_freq;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
    localparam int TCW = tx_depth_log2 + 1;
    localparam int TX_DEPTH = 2 ** tx_depth_log2;
    localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);

    logic       sel, wr_r, wr_hold, wr_fire;
    logic       tx_push, ctl_wr, flag_clr, tx_flush;
    logic [7:0] status, rd0;

    assign sel      = !iorq_n && ({a[7:1], 1'b0} == io_base);
    assign wr_fire  = enable && sel && !wr_r && !wr_hold;
    assign tx_push  = wr_fire && !a[0];
    assign ctl_wr   = wr_fire && a[0];
    assign flag_clr = ctl_wr && d[0];
    assign tx_flush = ctl_wr && d[1];

    // One action per bus access: the hold flag survives until the registered strobe goes high again.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_r    <= 1'b1;
            wr_hold <= 1'b0;
        end else if (enable) begin
            wr_r <= wr_n;
            if (wr_r)
                wr_hold <= 1'b0;
            else if (sel && !wr_hold)
                wr_hold <= 1'b1;
        end
    end

    logic [7:0]               tx_mem [TX_DEPTH];
    logic [tx_depth_log2-1:0] tx_wp, tx_rp;
    logic [TCW-1:0]           tx_fcnt;
    logic                     tx_full, tx_ne, tx_wr, tx_load, tx_ovf, tx_busy;
    logic                     tx_active;
    logic [CW-1:0]            tx_div;
    logic [3:0]               tx_bit;
    logic [8:0]               tx_sr;

    assign tx_full = (tx_fcnt == TX_FULL_CNT);
    assign tx_ne   = (tx_fcnt != '0);
    assign tx_wr   = tx_push && !tx_full;
    // Reload straight out of the stop bit so consecutive frames abut.
    assign tx_load = tx_ne && !tx_flush && (!tx_active || (tx_div == '0 && tx_bit == 4'd9));
    assign tx_busy = tx_active || tx_ne;

    always_ff @(posedge clk) begin
        if (tx_wr)
            tx_mem[tx_wp] <= d;
    end

    always_ff @(posedge clk) begin
        if (reset || tx_flush) begin
            tx_wp   <= '0;
            tx_rp   <= '0;
            tx_fcnt <= '0;
        end else begin
            if (tx_wr)
                tx_wp <= tx_wp + 1'b1;
            if (tx_load)
                tx_rp <= tx_rp + 1'b1;
            tx_fcnt <= tx_fcnt + TCW'(tx_wr) - TCW'(tx_load);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            tx_ovf <= 1'b0;
        else
            tx_ovf <= (tx_ovf && !flag_clr) || (tx_push && tx_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_active <= 1'b0;
            uart_tx   <= 1'b1;
            tx_div    <= '0;
            tx_bit    <= '0;
            tx_sr     <= '1;
        end else if (tx_load) begin
            tx_active <= 1'b1;
            uart_tx   <= 1'b0;
            tx_div    <= DIV_M1;
            tx_bit    <= '0;
            tx_sr     <= {1'b1, tx_mem[tx_rp]};
        end else if (tx_active) begin
            if (tx_div != '0) begin
                tx_div <= tx_div - 1'b1;
            end else if (tx_bit == 4'd9) begin
                tx_active <= 1'b0;
            end else begin
                uart_tx <= tx_sr[0];
                tx_sr   <= {1'b1, tx_sr[8:1]};
                tx_bit  <= tx_bit + 1'b1;
                tx_div  <= DIV_M1;
            end
        end
    end

`ifdef IP_UART_IO_RX_EN
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam int RCW = rx_depth_log2 + 1;
    localparam int RX_DEPTH = 2 ** rx_depth_log2;
    localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    rx_state_t     rx_state, rx_next;
    logic          rx_s1, rx_s2, rx_d;
    logic [CW-1:0] rx_div, rx_div_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_byte, rx_byte_n;
    logic          rx_done, rx_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            rx_state <= RX_IDLE;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            rx_state <= rx_next;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_byte  <= rx_byte_n;
        end
    end

    always_comb begin
        rx_next   = rx_state;
        rx_div_n  = (rx_div == '0) ? '0 : rx_div - 1'b1;
        rx_bit_n  = rx_bit;
        rx_byte_n = rx_byte;
        rx_done   = 1'b0;
        rx_bad    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_d && !rx_s2) begin
                    rx_next  = RX_START;
                    rx_div_n = HALF_M1;
                end
            end
            RX_START: begin
                // A start bit that is gone by mid-bit was a glitch.
                if (rx_div == '0) begin
                    if (!rx_s2) begin
                        rx_next  = RX_DATA;
                        rx_div_n = DIV_M1;
                        rx_bit_n = '0;
                    end else begin
                        rx_next = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (rx_div == '0) begin
                    rx_byte_n = {rx_s2, rx_byte[7:1]};
                    rx_div_n  = DIV_M1;
                    rx_bit_n  = rx_bit + 1'b1;
                    if (rx_bit == 3'd7)
                        rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_div == '0) begin
                    if (rx_s2) begin
                        rx_done = 1'b1;
                        rx_next = RX_IDLE;
                    end else begin
                        rx_bad  = 1'b1;
                        rx_next = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                if (rx_s2)
                    rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    logic [7:0]               rx_mem [RX_DEPTH];
    logic [rx_depth_log2-1:0] rx_wp, rx_rp;
    logic [RCW-1:0]           rx_fcnt;
    logic                     rx_full, rx_ne, rx_wr, rx_pop, rx_flush;
    logic                     rd_pend, rx_ovf, rx_ferr;

    assign rx_full  = (rx_fcnt == RX_FULL_CNT);
    assign rx_ne    = (rx_fcnt != '0);
    assign rx_wr    = rx_done && !rx_full;
    assign rx_pop   = enable && rd_pend && rd_n && rx_ne;
    assign rx_flush = ctl_wr && d[2];

    always_ff @(posedge clk) begin
        if (rx_wr)
            rx_mem[rx_wp] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (reset || rx_flush) begin
            rx_wp   <= '0;
            rx_rp   <= '0;
            rx_fcnt <= '0;
        end else begin
            if (rx_wr)
                rx_wp <= rx_wp + 1'b1;
            if (rx_pop)
                rx_rp <= rx_rp + 1'b1;
            rx_fcnt <= rx_fcnt + RCW'(rx_wr) - RCW'(rx_pop);
        end
    end

    // The head is consumed only once the CPU has released rd_n, so a held read sees a stable byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rx_ovf  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            if (enable) begin
                if (sel && !rd_n && !a[0] && rx_ne)
                    rd_pend <= 1'b1;
                else if (rd_n)
                    rd_pend <= 1'b0;
            end
            rx_ovf  <= (rx_ovf && !flag_clr) || (rx_done && rx_full);
            rx_ferr <= (rx_ferr && !flag_clr) || rx_bad;
        end
    end

    assign status = {2'b00, tx_ovf, rx_ferr, rx_ovf, rx_ne, tx_full, tx_busy};
    assign rd0    = rx_ne ? rx_mem[rx_rp] : 8'h00;
`else
    logic unused_rx;
    assign unused_rx = uart_rx;
    assign status    = {2'b00, tx_ovf, 3'b000, tx_full, tx_busy};
    assign rd0       = 8'hFF;
`endif

    assign q_en = sel && !rd_n;
    assign q    = q_en ? (a[0] ? status : rd0) : 8'h00;

endmodule

// File: tb/tb_ip_uart_io.sv
// tb/tb_ip_uart_io.sv - randomized self-checking bench for ip_uart_io against a frame-level reference model
module tb_ip_uart_io;
    localparam int         CLK_FREQ  = 27000000;
    localparam int         UART_FREQ = 115200;
    localparam int         DIV       = CLK_FREQ / UART_FREQ;
    localparam int         FRAME     = 10 * DIV;
    localparam logic [7:0] BASE      = 8'h10;

    logic       clk = 1'b0;
    logic       reset, enable, iorq_n, wr_n, rd_n, uart_rx;
    logic [7:0] a, d;
    logic [7:0] q;
    logic       q_en, uart_tx;

    always #5 clk = ~clk;

    ip_uart_io #(
        .clk_freq(CLK_FREQ), .uart_freq(UART_FREQ), .io_base(BASE),
        .tx_depth_log2(4), .rx_depth_log2(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .iorq_n(iorq_n), .wr_n(wr_n), .rd_n(rd_n),
        .a(a), .d(d), .q(q), .q_en(q_en), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit en_off = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus qualifier: two of every three cycles, unless forced off.
    initial begin
        enable = 1'b0;
        forever begin
            @(negedge clk);
            enable = !en_off && (cyc % 3 != 2);
        end
    end

    // Line monitor: decodes frames by mid-bit sampling, logs byte (-1 on bad framing) and start cycle.
    int mon_q[$];
    int mon_t[$];
    initial begin
        int t0;
        logic [7:0] b;
        bit ok;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                t0 = cyc;
                repeat (DIV / 2) @(negedge clk);
                ok = (uart_tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (DIV) @(negedge clk);
                ok = ok && (uart_tx === 1'b1);
                mon_q.push_back(ok ? int'(b) : -1);
                mon_t.push_back(t0);
            end
        end
    end

    initial begin
        #(2000000 * 10);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        a = addr; d = data; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (4) @(negedge clk);
        wr_n = 1'b1; iorq_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] val, output logic en);
        @(negedge clk);
        a = addr; iorq_n = 1'b0; rd_n = 1'b0;
        repeat (3) @(negedge clk);
        val = q; en = q_en;
        rd_n = 1'b1; iorq_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    logic [7:0] v;
    logic       ve;
    int         k, errs, exp_b, nb;
    logic [7:0] burst [18];
    int         exp_rx[$];

    initial begin
        reset = 1'b1; iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a = 8'h00; d = 8'h00; uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_uart_tx", uart_tx, 1);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_q", q, 0);
        check_eq("rst_q_en", q_en, 0);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("rst_status", v, 8'h00);
        check_eq("rst_status_qen", ve, 1);
        bus_read(8'h12, v, ve);
        check_eq("unsel_q", v, 8'h00);
        check_eq("unsel_qen", ve, 0);

        // Writes with the qualifier held low are ignored.
        en_off = 1'b1;
        bus_write(BASE, 8'h3C);
        repeat (20) @(negedge clk);
        en_off = 1'b0;
        repeat (6) @(negedge clk);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("en_gated_status", v, 8'h00);
        check_eq("en_gated_frames", mon_q.size(), 0);

        // Single frame: exact bit-level waveform.
        mon_q.delete(); mon_t.delete();
        fork
            bus_write(BASE, 8'h55);
            begin
                k = 0;
                while (k < 40 && uart_tx !== 1'b0) begin
                    @(negedge clk);
                    k++;
                end
                check_eq("t1_start_latency_ok", (k <= 7), 1);
                errs = 0;
                for (int j = 0; j < FRAME; j++) begin
                    nb = j / DIV;
                    exp_b = (nb == 0) ? 0 : (nb == 9) ? 1 : ((8'h55 >> (nb - 1)) & 1);
                    if (uart_tx !== exp_b[0]) errs++;
                    @(negedge clk);
                end
                check_eq("t1_wave_errs", errs, 0);
                check_eq("t1_idle_after", uart_tx, 1);
            end
        join
        repeat (DIV) @(negedge clk);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("t1_status_idle", v, 8'h00);
        check_eq("t1_mon_n", mon_q.size(), 1);
        if (mon_q.size() >= 1) check_eq("t1_mon_byte", mon_q[0], 8'h55);

        // Overfill: shifter takes one, FIFO holds depth, the rest are dropped.
        mon_q.delete(); mon_t.delete();
        for (int i = 0; i < 18; i++) begin
            burst[i] = 8'($urandom);
            bus_write(BASE, burst[i]);
        end
        bus_read(BASE + 8'd1, v, ve);
        check_eq("t2_status_ovf", v, 8'h23);
        bus_write(BASE + 8'd1, 8'h01);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("t2_status_clr", v, 8'h03);
        bus_write(BASE + 8'd1, 8'h02);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("t2_status_flush", v, 8'h01);
        repeat (FRAME + 50) @(negedge clk);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("t2_status_drained", v, 8'h00);
        check_eq("t2_mon_n", mon_q.size(), 1);
        if (mon_q.size() >= 1) check_eq("t2_mon_byte", mon_q[0], burst[0]);

        // Random burst: order preserved, frames abut.
        mon_q.delete(); mon_t.delete();
        nb = 2 + int'($urandom_range(0, 3));
        for (int i = 0; i < nb; i++) begin
            burst[i] = 8'($urandom);
            bus_write(BASE, burst[i]);
        end
        repeat (nb * FRAME + 100) @(negedge clk);
        check_eq("t3_mon_n", mon_q.size(), nb);
        for (int i = 0; i < nb && i < mon_q.size(); i++) begin
            check_eq("t3_mon_byte", mon_q[i], burst[i]);
            if (i > 0) check_eq("t3_gap", mon_t[i] - mon_t[i-1], FRAME);
        end

`ifdef IP_UART_IO_RX_EN
        // RX single frames: first is A5, then random.
        for (int r = 0; r < 3; r++) begin
            exp_b = (r == 0) ? 8'hA5 : int'($urandom_range(0, 255));
            send_frame(8'(exp_b), 1'b1);
            repeat (10) @(negedge clk);
            bus_read(BASE + 8'd1, v, ve);
            check_eq("rx_status_ne", v, 8'h04);
            bus_read(BASE, v, ve);
            check_eq("rx_byte", v, exp_b);
            check_eq("rx_byte_qen", ve, 1);
            bus_read(BASE + 8'd1, v, ve);
            check_eq("rx_status_popped", v, 8'h00);
        end

        send_frame(8'($urandom), 1'b0);
        repeat (DIV) @(negedge clk);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("rx_ferr_status", v, 8'h10);
        bus_write(BASE + 8'd1, 8'h01);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("rx_ferr_cleared", v, 8'h00);

        uart_rx = 1'b0;
        repeat ($urandom_range(1, DIV / 4)) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("rx_glitch_status", v, 8'h00);

        exp_rx.delete();
        for (int i = 0; i < 17; i++) begin
            exp_b = int'($urandom_range(0, 255));
            exp_rx.push_back(exp_b);
            send_frame(8'(exp_b), 1'b1);
        end
        repeat (10) @(negedge clk);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("rx_ovf_status", v, 8'h0C);
        for (int i = 0; i < 16; i++) begin
            bus_read(BASE, v, ve);
            check_eq("rx_fifo_byte", v, exp_rx[i]);
        end
        bus_read(BASE + 8'd1, v, ve);
        check_eq("rx_ovf_after_drain", v, 8'h08);
        bus_read(BASE, v, ve);
        check_eq("rx_empty_read", v, 8'h00);
        bus_write(BASE + 8'd1, 8'h01);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("rx_ovf_cleared", v, 8'h00);
`else
        bus_read(BASE, v, ve);
        check_eq("norx_read", v, 8'hFF);
        check_eq("norx_qen", ve, 1);
        send_frame(8'($urandom), 1'b1);
        send_frame(8'($urandom), 1'b0);
        repeat (DIV) @(negedge clk);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("norx_status", v, 8'h00);
`endif

        // Reset in the middle of a frame.
        bus_write(BASE, 8'h00);
        bus_write(BASE, 8'hC3);
        repeat ($urandom_range(DIV, 8 * DIV)) @(negedge clk);
        check_eq("mid_frame_low", uart_tx, 0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_uart_tx", uart_tx, 1);
        check_eq("rst_mid_q", q, 0);
        check_eq("rst_mid_qen", q_en, 0);
        reset = 1'b0;
        errs = 0;
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) errs++;
        end
        check_eq("rst_mid_line_idle", errs, 0);
        bus_read(BASE + 8'd1, v, ve);
        check_eq("rst_mid_status", v, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
